// File: rtl/fifo_aw_pkg.sv
// fifo_aw_pkg: shared types and helpers for fifo_adaptive_width.
//   rd_mode_e   : lanes-per-read selector
//   lanes_f     : decodes a read mode into a lane count, capped at max_ratio
//   cnt_width_f : width needed to hold an occupancy of 0..depth
package fifo_aw_pkg;

    typedef enum logic [1:0] {
        MODE_X1  = 2'd0,
        MODE_X2  = 2'd1,
        MODE_X4  = 2'd2,
        MODE_MAX = 2'd3
    } rd_mode_e;

    // MODE_MAX always means the widest configured read, even if 2**3 would differ.
    function automatic int unsigned lanes_f(input logic [1:0] mode, input int unsigned max_ratio);
        int unsigned l;
        l = 32'd1 << mode;
        if (mode == MODE_MAX || l > max_ratio) begin
            l = max_ratio;
        end
        return l;
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_adaptive_width_if.sv
// fifo_adaptive_width_if: write/read handshake and status bundle of the adaptive-width FIFO.
//   master : producer/consumer side (drives w_data, wr_en, par_inj, rd_en, rd_mode)
//   slave  : FIFO side (drives full, empty, r_data, r_lanes, count, status_reg, flags)
interface fifo_adaptive_width_if
    import fifo_aw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MAX_RATIO  = 4
) ();
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = cnt_width_f(Depth);
    localparam int unsigned LaneW = $clog2(MAX_RATIO) + 1;

    logic [DATA_WIDTH-1:0]           w_data;
    logic                            wr_en;
    logic                            par_inj;
    logic                            full;
    logic                            rd_en;
    logic [1:0]                      rd_mode;
    logic [MAX_RATIO*DATA_WIDTH-1:0] r_data;
    logic [LaneW-1:0]                r_lanes;
    logic                            empty;
    logic [CntW-1:0]                 count;
    logic [Depth-1:0]                status_reg;
    logic                            almost_full;
    logic                            almost_empty;
    logic                            parity_error;
    logic                            overflow;
    logic                            underflow;

    modport master (
        output w_data, wr_en, par_inj, rd_en, rd_mode,
        input  full, r_data, r_lanes, empty, count, status_reg,
        input  almost_full, almost_empty, parity_error, overflow, underflow
    );

    modport slave (
        input  w_data, wr_en, par_inj, rd_en, rd_mode,
        output full, r_data, r_lanes, empty, count, status_reg,
        output almost_full, almost_empty, parity_error, overflow, underflow
    );

endinterface

// File: rtl/fifo_aw_storage.sv
// fifo_aw_storage: byte array with parity plus a multi-lane registered read port.
//   clk, rst        : clock, synchronous active-high reset (read registers only)
//   wr_fire_i       : store {parity, w_data_i} at wr_ptr_i
//   rd_fire_i       : capture lanes_i bytes starting at rd_ptr_i (wrapping) into r_data_o
//   r_data_o        : lane 0 = oldest byte in the LSBs; lanes >= lanes_i read as 0
//   r_lanes_o       : lane count of the last captured word
//   parity_error_o  : any valid lane of the last captured word had bad parity
module fifo_aw_storage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned MAX_RATIO  = 4,
    parameter int unsigned LaneW      = $clog2(MAX_RATIO) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_fire_i,
    input  logic [ADDR_WIDTH-1:0]           wr_ptr_i,
    input  logic [DATA_WIDTH-1:0]           w_data_i,
    input  logic                            par_inj_i,
    input  logic                            rd_fire_i,
    input  logic [ADDR_WIDTH-1:0]           rd_ptr_i,
    input  logic [LaneW-1:0]                lanes_i,
    output logic [MAX_RATIO*DATA_WIDTH-1:0] r_data_o,
    output logic [LaneW-1:0]                r_lanes_o,
    output logic                            parity_error_o
);
    // Bit DATA_WIDTH holds the even-parity bit of the stored byte.
    logic [DATA_WIDTH:0]             mem_q [DEPTH];
    logic [MAX_RATIO*DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [LaneW-1:0]                r_lanes_q;
    logic                            perr_q, perr_d;
    logic [DATA_WIDTH:0]             ent;

    always_ff @(posedge clk) begin
        if (wr_fire_i) begin
            mem_q[wr_ptr_i] <= {(^w_data_i) ^ par_inj_i, w_data_i};
        end
    end

    // Pointer arithmetic in ADDR_WIDTH bits gives the wrap for free.
    always_comb begin
        r_data_d = '0;
        perr_d   = 1'b0;
        ent      = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            ent = mem_q[rd_ptr_i + ADDR_WIDTH'(i)];
            if (LaneW'(i) < lanes_i) begin
                r_data_d[i*DATA_WIDTH +: DATA_WIDTH] = ent[DATA_WIDTH-1:0];
                // XOR over data and stored parity is 1 exactly when they disagree.
                perr_d = perr_d | (^ent);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q  <= '0;
            r_lanes_q <= '0;
            perr_q    <= 1'b0;
        end else if (rd_fire_i) begin
            r_data_q  <= r_data_d;
            r_lanes_q <= lanes_i;
            perr_q    <= perr_d;
        end
    end

    assign r_data_o       = r_data_q;
    assign r_lanes_o      = r_lanes_q;
    assign parity_error_o = perr_q;

endmodule

// File: rtl/fifo_adaptive_width.sv
// fifo_adaptive_width: byte-write FIFO returning 1, 2 or 4 bytes per read.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of fifo_adaptive_width_if (write/read handshake, occupancy,
//              status_reg, almost_* thresholds, parity_error, sticky overflow/underflow)
module fifo_adaptive_width
    import fifo_aw_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned MAX_RATIO  = 4,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input logic                  clk,
    input logic                  rst,
    fifo_adaptive_width_if.slave bus
);
    localparam int unsigned CntW  = cnt_width_f(DEPTH);
    localparam int unsigned LaneW = $clog2(MAX_RATIO) + 1;

    logic [ADDR_WIDTH-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                 count_q, count_d;
    logic [DEPTH-1:0]                status_q, status_d;
    logic                            overflow_q, overflow_d, underflow_q, underflow_d;
    logic [LaneW-1:0]                lanes;
    logic [CntW-1:0]                 lanes_cnt;
    logic                            full, empty, wr_fire, rd_fire;
    logic [MAX_RATIO*DATA_WIDTH-1:0] r_data;
    logic [LaneW-1:0]                r_lanes;
    logic                            parity_error;

    assign lanes     = LaneW'(lanes_f(bus.rd_mode, MAX_RATIO));
    assign lanes_cnt = CntW'(lanes);
    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q < lanes_cnt);
    // No write-through: a full FIFO rejects writes even while a read frees space.
    assign wr_fire   = bus.wr_en & ~full;
    assign rd_fire   = bus.rd_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        status_d    = status_q;
        count_d     = count_q + CntW'(wr_fire) - (rd_fire ? lanes_cnt : '0);
        overflow_d  = overflow_q | (bus.wr_en & full);
        underflow_d = underflow_q | (bus.rd_en & empty);
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(lanes);
            for (int i = 0; i < MAX_RATIO; i++) begin
                if (LaneW'(i) < lanes) begin
                    status_d[rd_ptr_q + ADDR_WIDTH'(i)] = 1'b0;
                end
            end
        end
        // Applied after the clear so a write into a just-freed slot wins.
        if (wr_fire) begin
            wr_ptr_d           = wr_ptr_q + ADDR_WIDTH'(1);
            status_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            status_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_d;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_d;
            end
            if (wr_fire | rd_fire) begin
                count_q  <= count_d;
                status_q <= status_d;
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_aw_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .MAX_RATIO  (MAX_RATIO),
        .LaneW      (LaneW)
    ) u_storage (
        .clk            (clk),
        .rst            (rst),
        .wr_fire_i      (wr_fire),
        .wr_ptr_i       (wr_ptr_q),
        .w_data_i       (bus.w_data),
        .par_inj_i      (bus.par_inj),
        .rd_fire_i      (rd_fire),
        .rd_ptr_i       (rd_ptr_q),
        .lanes_i        (lanes),
        .r_data_o       (r_data),
        .r_lanes_o      (r_lanes),
        .parity_error_o (parity_error)
    );

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count_q;
    assign bus.status_reg   = status_q;
    assign bus.almost_full  = (count_q >= CntW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CntW'(AE_THRESH));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.r_data       = r_data;
    assign bus.r_lanes      = r_lanes;
    assign bus.parity_error = parity_error;

endmodule

// File: tb/tb_fifo_adaptive_width.sv
// Bench for fifo_adaptive_width: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_fifo_adaptive_width;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MR    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_adaptive_width_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_RATIO(MR)) bus ();

    fifo_adaptive_width #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_RATIO  (MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lanes_m(input int mode);
        if (mode == 3) return MR;
        return ((1 << mode) > MR) ? MR : (1 << mode);
    endfunction

    // Reference model: a plain byte queue with a bad-parity tag per byte.
    logic [7:0]  mq[$];
    bit          mbad[$];
    int          m_rd = 0;
    int          m_wr = 0;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    logic [31:0] m_rdata = '0;
    int          m_lanes = 0;
    bit          m_perr = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mbad.delete();
                m_rd = 0; m_wr = 0; m_ovf = 0; m_unf = 0;
                m_rdata = '0; m_lanes = 0; m_perr = 0;
            end else begin
                int  l;
                bit  is_full, rf, wf;
                l       = lanes_m(int'(bus.rd_mode));
                is_full = (mq.size() == DEPTH);
                rf      = bus.rd_en && (mq.size() >= l);
                wf      = bus.wr_en && !is_full;
                if (bus.wr_en && is_full) m_ovf = 1;
                if (bus.rd_en && !rf) m_unf = 1;
                if (rf) begin
                    m_rdata = '0;
                    m_perr  = 0;
                    for (int k = 0; k < l; k++) begin
                        m_rdata[8*k +: 8] = mq.pop_front();
                        m_perr = m_perr | mbad.pop_front();
                    end
                    m_rd    = (m_rd + l) % DEPTH;
                    m_lanes = l;
                end
                if (wf) begin
                    mq.push_back(bus.w_data);
                    mbad.push_back(bus.par_inj);
                    m_wr = (m_wr + 1) % DEPTH;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                logic [15:0] s;
                int          c;
                c = mq.size();
                s = '0;
                for (int k = 0; k < c; k++) s[(m_rd + k) % DEPTH] = 1'b1;
                check("count", bus.count, c);
                check("full", bus.full, c == DEPTH);
                check("empty", bus.empty, c < lanes_m(int'(bus.rd_mode)));
                check("almost_full", bus.almost_full, c >= DEPTH - 2);
                check("almost_empty", bus.almost_empty, c <= 2);
                check("status_reg", bus.status_reg, s);
                check("status_popcount", $countones(bus.status_reg), c);
                check("r_data", bus.r_data, m_rdata);
                check("r_lanes", bus.r_lanes, m_lanes);
                check("parity_error", bus.parity_error, m_perr);
                check("overflow", bus.overflow, m_ovf);
                check("underflow", bus.underflow, m_unf);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit inj);
        bus.wr_en   = 1'b1;
        bus.w_data  = d;
        bus.par_inj = inj;
        tick();
        bus.wr_en   = 1'b0;
        bus.par_inj = 1'b0;
    endtask

    task automatic rd(input logic [1:0] mode);
        bus.rd_en   = 1'b1;
        bus.rd_mode = mode;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.w_data  = '0;
        bus.wr_en   = 1'b0;
        bus.par_inj = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;

        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_almost_full", bus.almost_full, 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 16);
        check("fill_status", bus.status_reg, 16'hFFFF);
        wr(8'hFF, 1'b0);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_count", bus.count, 16);

        // X4 drain; last read uses MODE_MAX, which must also mean 4 lanes.
        rd(2'd2);
        check("x4_rd0", bus.r_data, 32'h03020100);
        check("x4_lanes", bus.r_lanes, 4);
        rd(2'd2);
        check("x4_rd1", bus.r_data, 32'h07060504);
        rd(2'd2);
        check("x4_rd2", bus.r_data, 32'h0B0A0908);
        rd(2'd3);
        check("xmax_rd3", bus.r_data, 32'h0F0E0D0C);
        check("drain_empty", bus.empty, 1);
        check("drain_status", bus.status_reg, 16'h0000);

        // Mixed modes.
        for (int i = 0; i < 7; i++) wr(8'hA0 + 8'(i), 1'b0);
        rd(2'd0);
        check("mix_x1", bus.r_data, 32'h000000A0);
        check("mix_x1_lanes", bus.r_lanes, 1);
        rd(2'd1);
        check("mix_x2", bus.r_data, 32'h0000A2A1);
        rd(2'd2);
        check("mix_x4", bus.r_data, 32'hA6A5A4A3);
        check("mix_count", bus.count, 0);
        rd(2'd0);
        check("unf_flag", bus.underflow, 1);
        check("unf_hold_rdata", bus.r_data, 32'hA6A5A4A3);

        // Move both pointers from 7 to 14, then read across the wrap.
        for (int i = 0; i < 7; i++) wr(8'h30 + 8'(i), 1'b0);
        rd(2'd2);
        rd(2'd1);
        rd(2'd0);
        check("pre_wrap_status", bus.status_reg, 16'h0000);
        for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i), 1'b0);
        check("wrap_status", bus.status_reg, 16'hC003);
        rd(2'd2);
        check("wrap_rdata", bus.r_data, 32'h14131211);
        check("wrap_perr", bus.parity_error, 0);

        // Simultaneous write and X4 read at count 5.
        for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i), 1'b0);
        bus.wr_en   = 1'b1;
        bus.w_data  = 8'h45;
        bus.rd_en   = 1'b1;
        bus.rd_mode = 2'd2;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("simul_count", bus.count, 2);
        check("simul_rdata", bus.r_data, 32'h43424140);
        rd(2'd1);
        check("simul_drain", bus.r_data, 32'h00004544);

        // Parity injection on lane 0.
        wr(8'h55, 1'b1);
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b0);
        rd(2'd2);
        check("par_rdata", bus.r_data, 32'h03020155);
        check("par_err", bus.parity_error, 1);

        // Idle: nothing moves.
        repeat (20) tick();
        check("idle_wr_ptr", dut.wr_ptr_q, 12);
        check("idle_rd_ptr", dut.rd_ptr_q, 12);
        check("idle_rdata", bus.r_data, 32'h03020155);

        // Reset mid-operation discards data and clears sticky flags.
        wr(8'h77, 1'b0);
        wr(8'h78, 1'b0);
        wr(8'h79, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_ovf", bus.overflow, 0);
        check("mid_rst_unf", bus.underflow, 0);
        check("mid_rst_rdata", bus.r_data, 0);
        check("mid_rst_perr", bus.parity_error, 0);
        check("mid_rst_status", bus.status_reg, 16'h0000);
        tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
